// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Contents:
//   state_t    - controller state: RUN (normal flow) or MD_BUSY (mult/div occupied)
//   MD_LAT_DEF - default mult/div occupancy after issue, in cycles
//   CNT_W_DEF  - default width of the stall/flush statistics counters
//   REG_ZERO   - register number of $0, which never carries a real dependency
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam int          MD_LAT_DEF = 8;
    localparam int          CNT_W_DEF  = 16;
    localparam logic [4:0]  REG_ZERO   = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline event statistics.
// Ports:
//   clk  in  1  clock, rising edge
//   rst  in  1  asynchronous reset, active-high; clears the count
//   inc  in  1  count this cycle
//   q    out W  current count; sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Increment only while below the all-ones ceiling so the count never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard detection and front-end sequencing for the 5-stage MIPS core.
// Detects load-use and HI/LO (mult/div) hazards, resolves taken-branch flushes,
// and drives the PC / IF-ID enables, the IF/ID flush and the ID/EX bubble select.
// Ports:
//   clk, rst         clock (rising) and async active-high reset
//   id_rs, id_rt     source registers of the instruction in ID
//   id_uses_rt       ID instruction reads Rt
//   id_uses_hilo     ID instruction touches HI/LO (mfhi/mflo/mult/div...)
//   idex_memread     ID/EX holds a load
//   idex_rt          destination of that load
//   ex_branch_taken  branch/jump resolved taken in EX
//   ex_md_start      mult/div issued from EX this cycle
//   pc_write         PC load enable
//   ifid_write       IF/ID load enable
//   ifid_flush       IF/ID clears to NOP on the next edge
//   idex_bubble      zero WB/M/EX controls into ID/EX on the next edge
//   md_busy          mult/div unit occupied
//   stall_cnt        saturating count of stall cycles
//   flush_cnt        saturating count of taken-branch flushes
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_uses_hilo,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             ex_branch_taken,
    input  logic             ex_md_start,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int               MC_W    = $clog2(MD_LAT + 1);
    localparam logic [MC_W-1:0]  MD_LOAD = MC_W'(MD_LAT);
    localparam logic [MC_W-1:0]  MC_ONE  = MC_W'(1);

    state_t            state;
    logic [MC_W-1:0]   md_cnt;
    logic              lu_hazard;
    logic              hl_hazard;
    logic              stall;

    // Mult/div occupancy tracker. A new issue while busy restarts the full
    // occupancy; the unit frees on the edge that ends its last busy cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (ex_md_start) begin
                        state  <= MD_BUSY;
                        md_cnt <= MD_LOAD;
                    end
                end
                MD_BUSY: begin
                    if (ex_md_start) begin
                        md_cnt <= MD_LOAD;
                    end else if (md_cnt == MC_ONE) begin
                        state  <= RUN;
                        md_cnt <= '0;
                    end else begin
                        md_cnt <= md_cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= RUN;
                    md_cnt <= '0;
                end
            endcase
        end
    end

    assign md_busy = (state == MD_BUSY);

    // Hazard terms. $0 is never a real dependency; Rt only matters when read.
    // A taken branch discards the ID instruction, so its hazard is moot.
    always_comb begin
        lu_hazard = idex_memread && (idex_rt != REG_ZERO) &&
                    ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
        hl_hazard = id_uses_hilo && (ex_md_start || (state == MD_BUSY));
        stall     = (lu_hazard || hl_hazard) && !ex_branch_taken;
    end

    // Front-end controls; branch flush takes priority over a stall.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ex_branch_taken),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl (MD_LAT=4, CNT_W=4).
// Directed scenarios followed by randomized cycles, all compared against a
// behavioural model that tracks "cycles of mult/div occupancy remaining" and
// integer event counts.
module tb_hazard_stall_ctrl;

    localparam int MD_LAT  = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       id_rs = '0;
    logic [4:0]       id_rt = '0;
    logic             id_uses_rt = 1'b0;
    logic             id_uses_hilo = 1'b0;
    logic             idex_memread = 1'b0;
    logic [4:0]       idex_rt = '0;
    logic             ex_branch_taken = 1'b0;
    logic             ex_md_start = 1'b0;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int check_count = 0;
    int pass_count  = 0;

    // Reference model state
    int busy_left = 0;
    int m_stall   = 0;
    int m_flush   = 0;

    hazard_stall_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_uses_hilo    (id_uses_hilo),
        .idex_memread    (idex_memread),
        .idex_rt         (idex_rt),
        .ex_branch_taken (ex_branch_taken),
        .ex_md_start     (ex_md_start),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .md_busy         (md_busy),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        busy_left = 0;
        m_stall   = 0;
        m_flush   = 0;
    endtask

    // Drive one cycle of inputs at the falling edge, check outputs against the
    // model, then advance the model to what the next rising edge should produce.
    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic uses_rt, input logic uses_hilo,
                                 input logic memread, input logic [4:0] ld_rt,
                                 input logic br, input logic md_start);
        bit lu, hl, stl;
        @(negedge clk);
        id_rs           = rs;
        id_rt           = rt;
        id_uses_rt      = uses_rt;
        id_uses_hilo    = uses_hilo;
        idex_memread    = memread;
        idex_rt         = ld_rt;
        ex_branch_taken = br;
        ex_md_start     = md_start;
        #1;
        lu  = memread && (ld_rt != 0) && ((ld_rt == rs) || (uses_rt && (ld_rt == rt)));
        hl  = uses_hilo && (md_start || (busy_left > 0));
        stl = (lu || hl) && !br;
        checkOutput("pc_write",    32'(pc_write),    32'(!stl));
        checkOutput("ifid_write",  32'(ifid_write),  32'(!stl));
        checkOutput("ifid_flush",  32'(ifid_flush),  32'(br));
        checkOutput("idex_bubble", 32'(idex_bubble), 32'(br || stl));
        checkOutput("md_busy",     32'(md_busy),     32'(busy_left > 0));
        checkOutput("stall_cnt",   32'(stall_cnt),   32'(m_stall));
        checkOutput("flush_cnt",   32'(flush_cnt),   32'(m_flush));
        if (md_start) busy_left = MD_LAT;
        else if (busy_left > 0) busy_left = busy_left - 1;
        if (stl && m_stall < CNT_MAX) m_stall++;
        if (br && m_flush < CNT_MAX) m_flush++;
    endtask

    task automatic idleCycle();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        id_uses_hilo = 1'b0; idex_memread = 1'b0; ex_branch_taken = 1'b0; ex_md_start = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_pc_write", 32'(pc_write), 32'd1);
        checkOutput("rst_md_busy",  32'(md_busy),  32'd0);
        checkOutput("rst_stall",    32'(stall_cnt), 32'd0);
        checkOutput("rst_flush",    32'(flush_cnt), 32'd0);
        #1 rst = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        checkOutput("init_pc_write",    32'(pc_write),    32'd1);
        checkOutput("init_ifid_write",  32'(ifid_write),  32'd1);
        checkOutput("init_ifid_flush",  32'(ifid_flush),  32'd0);
        checkOutput("init_idex_bubble", 32'(idex_bubble), 32'd0);
        checkOutput("init_md_busy",     32'(md_busy),     32'd0);
        checkOutput("init_stall_cnt",   32'(stall_cnt),   32'd0);
        doReset();

        // Load-use: exactly one bubble
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
        idleCycle();
        checkOutput("lu_stall_cnt_1", 32'(stall_cnt), 32'd1);

        // $0 and Rt gating
        applyStimulus(5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        applyStimulus(5'd1, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
        checkOutput("rt_unused_pc", 32'(pc_write), 32'd1);
        applyStimulus(5'd1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
        checkOutput("rt_used_pc", 32'(pc_write), 32'd0);

        // Branch beats stall
        applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
        checkOutput("br_pc_write", 32'(pc_write), 32'd1);
        idleCycle();
        checkOutput("br_flush_cnt", 32'(flush_cnt), 32'd1);
        checkOutput("br_stall_cnt", 32'(stall_cnt), 32'd2);

        // HI/LO hazard across a mult/div occupancy
        doReset();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < MD_LAT; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        end
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("md_free_pc",   32'(pc_write),  32'd1);
        checkOutput("md_free_busy", 32'(md_busy),   32'd0);
        checkOutput("md_stall_cnt", 32'(stall_cnt), 32'd5);

        // Saturation
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
        end
        idleCycle();
        checkOutput("sat_stall_cnt", 32'(stall_cnt), 32'(CNT_MAX));

        // Async reset mid-MD_BUSY
        doReset();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        checkOutput("arst_md_busy",  32'(md_busy),  32'd0);
        checkOutput("arst_pc_write", 32'(pc_write), 32'd1);
        checkOutput("arst_stall",    32'(stall_cnt), 32'd0);
        #1 rst = 1'b0;
        modelReset();

        // Randomized cycles with a small register range to provoke matches
        for (int i = 0; i < 400; i++) begin
            applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0));
        end
        idleCycle();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
